// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so trial always fits and its MSB is a true sign.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};
  assign rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o   = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake.
// Optional early-exit path enabled by defining SEQ_DIVIDER_FASTPATH_EN.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_orig_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             neg_quo_q, neg_rem_q, zero_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] zero_quot;

  assign dvd_neg   = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg   = signed_i & divisor_i[WIDTH-1];
  assign dvd_abs   = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_abs   = dvs_neg ? -divisor_i : divisor_i;
  assign zero_quot = {WIDTH{DIV_ZERO_QUOT[0]}};

`ifdef SEQ_DIVIDER_FASTPATH_EN
  logic take_fast;
  assign take_fast = (divisor_i == '0) || (dvd_abs < dvs_abs);
`endif

  seq_divider_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_orig_q  <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            dvs_q      <= dvs_abs;
            dvd_orig_q <= dividend_i;
            neg_quo_q  <= dvd_neg ^ dvs_neg;
            neg_rem_q  <= dvd_neg;
            zero_q     <= (divisor_i == '0);
            count_q    <= '0;
            busy_q     <= 1'b1;
`ifdef SEQ_DIVIDER_FASTPATH_EN
            if (take_fast) begin
              state_q <= FIX;
              quo_q   <= '0;
              rem_q   <= dvd_abs;
            end else begin
              state_q <= CALC;
              quo_q   <= dvd_abs;
              rem_q   <= '0;
            end
`else
            state_q <= CALC;
            quo_q   <= dvd_abs;
            rem_q   <= '0;
`endif
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          // Magnitudes are exact; signs restored here (quotient toward zero).
          if (zero_q) begin
            quotient_q  <= zero_quot;
            remainder_q <= dvd_orig_q;
          end else begin
            quotient_q  <= neg_quo_q ? -quo_q : quo_q;
            remainder_q <= neg_rem_q ? -rem_q : rem_q;
          end
          div_zero_q <= zero_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          count_q    <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int WIDTH    = 32;
  localparam int LAT_FULL = WIDTH + 2;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division on 64-bit integers, plus the div-by-zero rule.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z, output int lat);
    longint sa, sb, qq, rr;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
      z  = 1'b0;
    end
    lat = LAT_FULL;
`ifdef SEQ_DIVIDER_FASTPATH_EN
    begin
      longint ma, mb;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      if (b == 32'd0 || ma < mb) lat = 2;
    end
`endif
  endfunction

  // Called between edges; the next rising edge samples start_i.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend_i = a;
    divisor_i  = b;
    signed_i   = s;
    start_i    = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int poke_at, output int lat, output int bc, output logic fb);
    lat = 0;
    bc  = 0;
    fb  = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) fb = busy_o;
      if (busy_o) bc++;
      if (poke_at > 0 && lat == poke_at) begin
        start_i    = 1'b1;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = ~signed_i;
      end else if (poke_at > 0 && lat == poke_at + 1) begin
        start_i = 1'b0;
      end
      if (done_o === 1'b1 || lat >= 100) break;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int lat, input int bc, input logic fb);
    logic [31:0] eq, er;
    logic        ez;
    int          el;
    model(a, b, s, eq, er, ez, el);
    $display("op %s a=0x%08h b=0x%08h signed=%0d q=0x%08h r=0x%08h dz=%0d lat=%0d",
             tag, a, b, s, quotient_o, remainder_o, div_zero_o, lat);
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(el - 1));
    check({tag, "_busy_first"}, {31'b0, fb}, 32'd1);
    check({tag, "_quot"}, quotient_o, eq);
    check({tag, "_rem"}, remainder_o, er);
    check({tag, "_dz"}, {31'b0, div_zero_o}, {31'b0, ez});
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int poke_at);
    int   lat, bc;
    logic fb;
    @(negedge clk);
    launch(a, b, s);
    wait_done(poke_at, lat, bc, fb);
    check_op(tag, a, b, s, lat, bc, fb);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done_o}, 32'd0);
  endtask

  initial begin
    int          lat, bc, extra;
    logic        fb;
    logic [31:0] eq, er, ra, rb;
    logic        ez, rs;
    int          el;

    rst_i      = 1'b0;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    #2 rst_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_quot", quotient_o, 32'd0);
    check("rst_rem", remainder_o, 32'd0);
    check("rst_dz", {31'b0, div_zero_o}, 32'd0);
    rst_i = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 0);
    run_op("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 0);
    run_op("s_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 0);
    run_op("div_zero", 32'h1234_5678, 32'd0, 1'b0, 0);
    run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("u_ovf_ops", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);

    // Mid-operation start pulse (with scrambled inputs) must be ignored.
    run_op("ignored_start", 32'd1000, 32'd7, 1'b0, 10);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check("single_done", 32'(extra), 32'd0);
    model(32'd1000, 32'd7, 1'b0, eq, er, ez, el);
    check("held_quot", quotient_o, eq);
    check("held_rem", remainder_o, er);

    // start_i asserted during the done cycle is accepted immediately.
    @(negedge clk);
    launch(32'd50, 32'd6, 1'b0);
    wait_done(0, lat, bc, fb);
    check_op("b2b_first", 32'd50, 32'd6, 1'b0, lat, bc, fb);
    launch(32'd1000, 32'd7, 1'b0);
    wait_done(0, lat, bc, fb);
    check_op("b2b_second", 32'd1000, 32'd7, 1'b0, lat, bc, fb);

    // Asynchronous reset mid-operation clears outputs and abandons the op.
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy_o}, 32'd0);
    check("arst_done", {31'b0, done_o}, 32'd0);
    check("arst_quot", quotient_o, 32'd0);
    check("arst_rem", remainder_o, 32'd0);
    check("arst_dz", {31'b0, div_zero_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check("arst_no_done", 32'(extra), 32'd0);
    run_op("after_rst_9_3", 32'd9, 32'd3, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = ra ^ 32'($urandom_range(0, 255));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rs, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
